// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART <-> ALU command bridge: state encoding,
// default widths and the opcodes the companion ALU understands.
package uart_alu_interface_pkg;

   localparam int DATA_SIZE_DEF = 8;
   localparam int OP_SIZE_DEF   = 6;
   localparam int STATE_W       = 3;

   localparam logic [STATE_W-1:0] ST_WAIT_A  = 3'd0;
   localparam logic [STATE_W-1:0] ST_WAIT_B  = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT_OP = 3'd2;
   localparam logic [STATE_W-1:0] ST_EXEC    = 3'd3;
   localparam logic [STATE_W-1:0] ST_SEND    = 3'd4;
   localparam logic [STATE_W-1:0] ST_WAIT_TX = 3'd5;

   localparam logic [OP_SIZE_DEF-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_SIZE_DEF-1:0] OP_SUB = 6'b100010;

   // States in which the inter-byte timeout is armed.
   function automatic logic state_times_out(input logic [STATE_W-1:0] s);
      return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
   endfunction

   // States in which an incoming byte cannot be used and is discarded.
   function automatic logic state_drops_rx(input logic [STATE_W-1:0] s);
      return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
   endfunction

endpackage

// File: rtl/uart_alu_timeout.sv
// Inter-byte watchdog: loads TIMEOUT_CYCLES-1, counts down while enabled,
// saturates at zero and flags expiry during the cycle it sits at zero.
module uart_alu_timeout #(
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = LOAD_VAL;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A load in the same cycle means a byte arrived, which always beats expiry.
   assign expire_o = en_i && !load_i && (count_q == '0);

endmodule

// File: rtl/uart_alu_interface.sv
// Assembles A, B, opcode from received UART bytes, drives an external
// combinational ALU, and returns the result through the UART transmitter.
module uart_alu_interface
   import uart_alu_interface_pkg::*;
#(
   parameter int DATA_SIZE      = DATA_SIZE_DEF,
   parameter int OP_SIZE        = OP_SIZE_DEF,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [DATA_SIZE-1:0] i_rx_data,
   input  logic                 i_rx_done,
   input  logic                 i_tx_done,
   output logic [DATA_SIZE-1:0] o_tx_data,
   output logic                 o_tx_start,
   output logic [DATA_SIZE-1:0] o_alu_a,
   output logic [DATA_SIZE-1:0] o_alu_b,
   output logic [OP_SIZE-1:0]   o_alu_op,
   input  logic [DATA_SIZE-1:0] i_alu_result,
   output logic                 o_busy,
   output logic                 o_error,
   output logic [STATE_W-1:0]   o_state
);

   logic [STATE_W-1:0]   state_q,   state_d;
   logic [DATA_SIZE-1:0] alu_a_q,   alu_a_d;
   logic [DATA_SIZE-1:0] alu_b_q,   alu_b_d;
   logic [OP_SIZE-1:0]   alu_op_q,  alu_op_d;
   logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
   logic                 error_q,   error_d;

   logic to_load;
   logic to_en;
   logic to_expire;

   // Every received byte restarts the watchdog; entry into WAIT_B/WAIT_OP
   // only ever happens on a received byte, so this also covers state entry.
   assign to_load = i_rx_done;
   assign to_en   = state_times_out(state_q) && !i_rx_done;

   uart_alu_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (i_clk),
      .reset_i  (i_reset),
      .load_i   (to_load),
      .en_i     (to_en),
      .expire_o (to_expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_WAIT_A;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         tx_data_q <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         tx_data_q <= tx_data_d;
         error_q   <= error_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      tx_data_d = tx_data_q;
      error_d   = state_drops_rx(state_q) && i_rx_done;
      case (state_q)
         ST_WAIT_A: begin
            if (i_rx_done) begin
               alu_a_d = i_rx_data;
               state_d = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            if (i_rx_done) begin
               alu_b_d = i_rx_data;
               state_d = ST_WAIT_OP;
            end else if (to_expire) begin
               state_d = ST_WAIT_A;
               error_d = 1'b1;
            end
         end
         ST_WAIT_OP: begin
            if (i_rx_done) begin
               alu_op_d = i_rx_data[OP_SIZE-1:0];
               state_d  = ST_EXEC;
            end else if (to_expire) begin
               state_d = ST_WAIT_A;
               error_d = 1'b1;
            end
         end
         // The operand registers settled last cycle, so the ALU output is valid now.
         ST_EXEC: begin
            tx_data_d = i_alu_result;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            state_d = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (i_tx_done) begin
               state_d = ST_WAIT_A;
            end
         end
         default: begin
            state_d = ST_WAIT_A;
         end
      endcase
   end

   always_comb begin
      o_tx_start = (state_q == ST_SEND);
      o_busy     = (state_q != ST_WAIT_A);
   end

   assign o_tx_data = tx_data_q;
   assign o_alu_a   = alu_a_q;
   assign o_alu_b   = alu_b_q;
   assign o_alu_op  = alu_op_q;
   assign o_error   = error_q;
   assign o_state   = state_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: table of commands, hand-written corner
// sequences and random traffic, all checked every cycle against a byte-level model.
module tb_uart_alu_interface;
   import uart_alu_interface_pkg::*;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_done = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] alu_result;
   logic [7:0] tx_data;
   logic       tx_start;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic       busy;
   logic       err;
   logic [2:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_alu_interface #(
      .DATA_SIZE      (8),
      .OP_SIZE        (6),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_rx_data    (rx_data),
      .i_rx_done    (rx_done),
      .i_tx_done    (tx_done),
      .o_tx_data    (tx_data),
      .o_tx_start   (tx_start),
      .o_alu_a      (alu_a),
      .o_alu_b      (alu_b),
      .o_alu_op     (alu_op),
      .i_alu_result (alu_result),
      .o_busy       (busy),
      .o_error      (err),
      .o_state      (state)
   );

   function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      logic [7:0] r;
      if (op == OP_ADD) r = a + b;
      else if (op == OP_SUB) r = a - b;
      else r = a ^ b;
      return r;
   endfunction

   always_comb alu_result = ref_alu(alu_a, alu_b, alu_op);

   // Byte-level model: how many bytes of the command are held, how long since
   // the last one, and where the reply is in its exec/send/wait-for-tx life.
   int         m_n = 0;
   int         m_idle = 0;
   int         m_phase = 0;
   logic [7:0] m_a = 8'h00;
   logic [7:0] m_b = 8'h00;
   logic [5:0] m_op = 6'h00;
   logic [7:0] m_tx = 8'h00;
   logic       m_err = 1'b0;

   task automatic model_edge(input logic rx, input logic [7:0] d, input logic txd,
                             input logic r);
      if (r) begin
         m_n = 0; m_idle = 0; m_phase = 0;
         m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00; m_err = 1'b0;
      end else begin
         m_err = 1'b0;
         case (m_phase)
            0: begin
               if (rx) begin
                  if (m_n == 0) begin m_a = d; m_n = 1; m_idle = 0; end
                  else if (m_n == 1) begin m_b = d; m_n = 2; m_idle = 0; end
                  else begin m_op = d[5:0]; m_n = 0; m_phase = 1; end
               end else if (m_n != 0) begin
                  m_idle++;
                  if (m_idle >= TO) begin m_n = 0; m_idle = 0; m_err = 1'b1; end
               end
            end
            1: begin m_tx = ref_alu(m_a, m_b, m_op); m_phase = 2; m_err = rx; end
            2: begin m_phase = 3; m_err = rx; end
            default: begin
               if (txd) m_phase = 0;
               m_err = rx;
            end
         endcase
      end
   endtask

   function automatic logic [2:0] model_state();
      case (m_phase)
         1: return ST_EXEC;
         2: return ST_SEND;
         3: return ST_WAIT_TX;
         default: return (m_n == 0) ? ST_WAIT_A : (m_n == 1) ? ST_WAIT_B : ST_WAIT_OP;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("tx_data", 32'(tx_data), 32'(m_tx));
      chk("tx_start", 32'(tx_start), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'((m_phase != 0) || (m_n != 0)));
      chk("error", 32'(err), 32'(m_err));
      chk("state", 32'(state), 32'(model_state()));
   endtask

   // One clock: present inputs, advance model with the edge, sample 1 ns later.
   task automatic step(input logic rx, input logic [7:0] d, input logic txd, input logic r);
      rx_done = rx; rx_data = d; tx_done = txd; reset = r;
      @(posedge clk);
      model_edge(rx, d, txd, r);
      #1;
      rx_done = 1'b0; tx_done = 1'b0; reset = 1'b0;
      check_model();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                          input int gap, input logic [7:0] res, input int txw);
      step(1'b1, a, 1'b0, 1'b0);
      idle(gap - 1);
      step(1'b1, b, 1'b0, 1'b0);
      idle(gap - 1);
      step(1'b1, {2'b00, op}, 1'b0, 1'b0);
      chk("cmd_a", 32'(alu_a), 32'(a));
      chk("cmd_b", 32'(alu_b), 32'(b));
      chk("cmd_op", 32'(alu_op), 32'(op));
      chk("tx_start_early", 32'(tx_start), 32'(0));
      idle(1);
      chk("tx_start_lat2", 32'(tx_start), 32'(1));
      chk("tx_result", 32'(tx_data), 32'(res));
      chk("cmd_no_err", 32'(err), 32'(0));
      idle(1 + txw);
      chk("busy_wait_tx", 32'(busy), 32'(1));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("idle_after_tx", 32'(busy), 32'(0));
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      int         gap;
      logic [7:0] res;
      int         txw;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] d;
      logic       rx;

      vecs[0] = '{8'h05, 8'h03, 6'b100000, 10, 8'h08, 3};
      vecs[1] = '{8'h03, 8'h05, 6'b100010, 10, 8'hFE, 5};
      vecs[2] = '{8'hFF, 8'h01, 6'b100000, 1,  8'h00, 0};
      vecs[3] = '{8'h80, 8'h80, 6'b100010, 2,  8'h00, 1};
      vecs[4] = '{8'h01, 8'h01, 6'b100000, TO, 8'h02, 2};
      vecs[5] = '{8'hC8, 8'h64, 6'b100000, TO - 1, 8'h2C, 4};

      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst_state", 32'(state), 32'(ST_WAIT_A));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_tx_start", 32'(tx_start), 32'(0));
      idle(3);

      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].gap, vecs[i].res, vecs[i].txw);
         idle(2);
      end

      // Timeout after operand A: error exactly TO clocks after the byte.
      step(1'b1, 8'h11, 1'b0, 1'b0);
      idle(TO - 1);
      chk("to_not_yet", 32'(err), 32'(0));
      chk("to_still_busy", 32'(busy), 32'(1));
      idle(1);
      chk("to_err", 32'(err), 32'(1));
      chk("to_state", 32'(state), 32'(ST_WAIT_A));
      idle(1);
      chk("to_err_once", 32'(err), 32'(0));
      run_cmd(8'h01, 8'h01, OP_ADD, 4, 8'h02, 1);

      // Timeout while waiting for the opcode.
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      step(1'b1, 8'hBB, 1'b0, 1'b0);
      idle(TO);
      chk("to_op_err", 32'(err), 32'(1));
      chk("to_op_state", 32'(state), 32'(ST_WAIT_A));

      // Byte dropped while waiting for tx done.
      step(1'b1, 8'h10, 1'b0, 1'b0);
      step(1'b1, 8'h20, 1'b0, 1'b0);
      step(1'b1, {2'b00, OP_ADD}, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 8'h77, 1'b0, 1'b0);
      chk("drop_err", 32'(err), 32'(1));
      chk("drop_state", 32'(state), 32'(ST_WAIT_TX));
      chk("drop_a_kept", 32'(alu_a), 32'(8'h10));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drop_err_once", 32'(err), 32'(0));
      run_cmd(8'h07, 8'h09, OP_ADD, 3, 8'h10, 1);

      // Byte coinciding with tx done: leave WAIT_TX, still drop the byte.
      step(1'b1, 8'h30, 1'b0, 1'b0);
      step(1'b1, 8'h10, 1'b0, 1'b0);
      step(1'b1, {2'b00, OP_SUB}, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      chk("tie_tx_err", 32'(err), 32'(1));
      chk("tie_tx_state", 32'(state), 32'(ST_WAIT_A));
      chk("tie_tx_result", 32'(tx_data), 32'(8'h20));
      run_cmd(8'h09, 8'h04, OP_SUB, 2, 8'h05, 0);

      // Reset mid-command.
      step(1'b1, 8'h05, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst_mid_a", 32'(alu_a), 32'(0));
      chk("rst_mid_b", 32'(alu_b), 32'(0));
      chk("rst_mid_op", 32'(alu_op), 32'(0));
      chk("rst_mid_tx", 32'(tx_data), 32'(0));
      chk("rst_mid_start", 32'(tx_start), 32'(0));
      chk("rst_mid_busy", 32'(busy), 32'(0));
      chk("rst_mid_err", 32'(err), 32'(0));
      run_cmd(8'h02, 8'h02, OP_ADD, 3, 8'h04, 2);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) idle(TO + 2);
         rx = ($urandom_range(0, 4) == 0);
         d = 8'($urandom);
         if (m_n == 2 && m_phase == 0 && $urandom_range(0, 3) != 0)
            d = $urandom_range(0, 1) ? {2'b00, OP_ADD} : {2'b00, OP_SUB};
         step(rx, d, ($urandom_range(0, 5) == 0), ($urandom_range(0, 399) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Host-side companion to the UART top; sits on the UART's parallel side.
- Consumes received bytes (rx data + done tick) and assembles an ALU command: operand A, then operand B, then opcode.
- Presents the command to an external combinational ALU, captures the result, and hands it back to the UART transmitter (tx data + start), waiting for tx done.
- Guards against partial commands with an inter-byte timeout.

Parameters:
- DATA_SIZE, 8, width of UART bytes, operands and result.
- OP_SIZE, 6, opcode width; taken from the low OP_SIZE bits of the third byte.
- TIMEOUT_CYCLES, 5000000, maximum clock cycles allowed between bytes of one command (must be ≥ 2).

Ports:
- i_clk  in  1  system clock; one clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  DATA_SIZE  received byte from UART, valid when i_rx_done is high.
- i_rx_done  in  1  one-cycle pulse: new byte on i_rx_data.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- o_tx_data  out  DATA_SIZE  byte to transmit.
- o_tx_start  out  1  one-cycle transmit request.
- o_alu_a  out  DATA_SIZE  operand A to ALU.
- o_alu_b  out  DATA_SIZE  operand B to ALU.
- o_alu_op  out  OP_SIZE  opcode to ALU.
- i_alu_result  in  DATA_SIZE  combinational ALU result.
- o_busy  out  1  high in any state other than WAIT_A.
- o_error  out  1  one-cycle pulse on timeout or dropped byte.

Behaviour:
- Reset (sync, active-high, i_reset): state WAIT_A. All outputs and registers cleared to 0, including the timeout counter. Reset wins over every other event, including mid-command and mid-transmit; any pending command is discarded.
- All outputs are registered. o_tx_start and o_busy are functions of the state register only.
- States and transitions:
  - WAIT_A: on i_rx_done, o_alu_a <= i_rx_data; go to WAIT_B.
  - WAIT_B: on i_rx_done, o_alu_b <= i_rx_data; go to WAIT_OP.
  - WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[OP_SIZE-1:0]; go to EXEC.
  - EXEC (1 cycle, ALU inputs now stable): o_tx_data <= i_alu_result; go to SEND.
  - SEND (1 cycle): o_tx_start = 1; go to WAIT_TX.
  - WAIT_TX: on i_tx_done, go to WAIT_A.
- Latency: the opcode's i_rx_done cycle is cycle 0; EXEC is entered at cycle 1 and o_tx_start is high during cycle 2.
- o_alu_a, o_alu_b and o_alu_op hold their values until overwritten by the next command; they are not cleared on return to WAIT_A.
- o_tx_data holds its value until the next EXEC.
- Timeout:
  - The counter runs only in WAIT_B and WAIT_OP.
  - It clears on entry to those states and on every i_rx_done.
  - When it reaches TIMEOUT_CYCLES-1 without i_rx_done, the next cycle returns to WAIT_A and pulses o_error for one cycle.
  - i_rx_done in the expiry cycle takes priority: the byte is accepted and there is no error.
- Dropped bytes: i_rx_done in EXEC, SEND or WAIT_TX discards the byte and pulses o_error. State is unaffected.
  - If i_rx_done coincides with i_tx_done in WAIT_TX, the transition to WAIT_A happens, the byte is dropped, and o_error pulses.
- i_tx_done outside WAIT_TX is ignored.
- No arithmetic inside the block other than the timeout counter. Counter width is $clog2(TIMEOUT_CYCLES); it saturates and never wraps.

Decomposition:
- Shared package: state encoding (WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX as a 3-bit localparam set) and default DATA_SIZE/OP_SIZE constants, also used by the ALU and the board top.
- One natural sub-module: uart_alu_timeout, a loadable down-counter with clear, enable and an expiry pulse.
- FSM and output registers stay in the parent.

Test Plan (bench uses TIMEOUT_CYCLES=20 and a behavioural ALU where op 6'b100000 = add, 6'b100010 = sub):
- Command: rx bytes 0x05, 0x03, 0x20 (rx pulses 10 cycles apart) -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'b100000; o_tx_start high exactly 2 cycles after the third pulse with o_tx_data=0x08; o_busy high until i_tx_done.
- Subtraction with wrap: bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE, single o_tx_start pulse, no o_error.
- Timeout: byte 0x11, then silence -> exactly 20 cycles later o_error pulses once and the state is WAIT_A; next bytes 0x01, 0x01, 0x20 yield o_tx_data=0x02.
- Expiry tie: second byte arrives in the expiry cycle -> accepted, no o_error, command completes normally.
- Drop during transmit: byte 0x77 during WAIT_TX -> o_error pulse, no state change; after i_tx_done the next full command executes correctly.
- Reset mid-command: after bytes 0x05, 0x03, assert i_reset for 1 cycle -> all outputs 0, o_busy 0; new command 0x02, 0x02, 0x20 gives o_tx_data=0x04.
